// File: rtl/din_sync_debounce_if.sv
// Signal bundle between the input-conditioning stage and whatever drives/consumes it.
// The DUT takes the slave modport; the stimulus or upstream logic takes the master modport.
interface din_sync_debounce_if #(
  parameter int GLITCH_W = 8
);
  logic                din_async;
  logic                en;
  logic                clr_glitch;
  logic                dout;
  logic                busy;
  logic                glitch;
  logic [GLITCH_W-1:0] glitch_cnt;

  modport master (
    output din_async, en, clr_glitch,
    input  dout, busy, glitch, glitch_cnt
  );

  modport slave (
    input  din_async, en, clr_glitch,
    output dout, busy, glitch, glitch_cnt
  );
endinterface

// File: rtl/din_sync_debounce.sv
// Synchronises an asynchronous level into clk and only passes changes that stay stable
// for STABLE_CNT consecutive samples; aborted candidates are reported and counted.
module din_sync_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CNT  = 8,
  parameter bit RESET_VAL   = 1'b0,
  parameter int GLITCH_W    = 8
) (
  input logic               clk,
  input logic               rst_n,
  din_sync_debounce_if.slave bus
);

  localparam int CNT_W = $clog2(STABLE_CNT + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(STABLE_CNT - 1);
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("din_sync_debounce: SYNC_STAGES must be 2..4");
  end
  if (STABLE_CNT < 2 || STABLE_CNT > 65535) begin : g_bad_stable
    $error("din_sync_debounce: STABLE_CNT must be 2..65535");
  end

  typedef enum logic {
    IDLE = 1'b0,
    QUAL = 1'b1
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   dout_q, dout_d;
  logic                   busy_q;
  logic                   glitch_q, glitch_d;
  logic [GLITCH_W-1:0]    glitch_cnt_q, glitch_cnt_d;
  logic [GLITCH_W-1:0]    glitch_base;
  logic                   s;

  // The raw input touches nothing but the first synchroniser flop.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.din_async};
  assign s      = sync_q[SYNC_STAGES-1];

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    glitch_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.en && (s != dout_q)) begin
          state_d = QUAL;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      QUAL: begin
        if (!bus.en) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (s == dout_q) begin
          state_d  = IDLE;
          cnt_d    = '0;
          glitch_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          dout_d  = s;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Clear wins first, then a coincident abort is still counted.
  always_comb begin
    glitch_base  = bus.clr_glitch ? '0 : glitch_cnt_q;
    glitch_cnt_d = glitch_base;
    if (glitch_d && (glitch_base != GLITCH_MAX)) begin
      glitch_cnt_d = glitch_base + GLITCH_W'(1);
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= {SYNC_STAGES{RESET_VAL}};
      state_q      <= IDLE;
      cnt_q        <= '0;
      dout_q       <= RESET_VAL;
      busy_q       <= 1'b0;
      glitch_q     <= 1'b0;
      glitch_cnt_q <= '0;
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      busy_q       <= (state_d == QUAL);
      glitch_q     <= glitch_d;
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.busy       = busy_q;
  assign bus.glitch     = glitch_q;
  assign bus.glitch_cnt = glitch_cnt_q;

  a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n) cnt_q < CNT_W'(STABLE_CNT));
  a_idle_cnt:  assert property (@(posedge clk) disable iff (!rst_n) (state_q == IDLE) |-> (cnt_q == '0));
  a_glitch_ib: assert property (@(posedge clk) disable iff (!rst_n) glitch_q |-> !busy_q);

endmodule

// File: tb/tb_din_sync_debounce.sv
// Self-checking bench for din_sync_debounce: a latency table, directed corner sequences,
// and a randomized run compared against a run-length model of the qualification rules.
module tb_din_sync_debounce;

  localparam int SYNC_STAGES = 2;
  localparam int STABLE_CNT  = 8;
  localparam int GLITCH_W    = 8;
  localparam int GMAX        = (1 << GLITCH_W) - 1;

  logic clk;
  logic rst_n;

  din_sync_debounce_if #(.GLITCH_W(GLITCH_W)) bus ();

  din_sync_debounce #(
    .SYNC_STAGES(SYNC_STAGES),
    .STABLE_CNT (STABLE_CNT),
    .RESET_VAL  (1'b0),
    .GLITCH_W   (GLITCH_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;
  int glitch_seen;
  int busy_seen;
  int dout_hi_seen;

  typedef struct {
    logic       din;
    logic       en;
    logic       clr;
    logic       exp_dout;
    logic       exp_busy;
    logic       exp_glitch;
    logic [7:0] exp_gcnt;
  } vec_t;

  vec_t tbl[12];

  // Reference model state: synchroniser modelled as a pure delay queue, qualification as a run length.
  logic m_q[$];
  int   m_run;
  logic m_dout;
  logic m_glitch;
  int   m_gcnt;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    glitch_seen  += int'(bus.glitch);
    busy_seen    += int'(bus.busy);
    dout_hi_seen += int'(bus.dout);
  endtask

  task automatic clear_seen();
    glitch_seen  = 0;
    busy_seen    = 0;
    dout_hi_seen = 0;
  endtask

  task automatic do_reset(input logic din_v);
    bus.din_async  = din_v;
    bus.en         = 1'b1;
    bus.clr_glitch = 1'b0;
    rst_n          = 1'b0;
    #12;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_seen();
  endtask

  task automatic pulse(input int n);
    bus.din_async = 1'b1;
    repeat (n) step();
    bus.din_async = 1'b0;
  endtask

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < SYNC_STAGES; i++) m_q.push_back(1'b0);
    m_run    = 0;
    m_dout   = 1'b0;
    m_glitch = 1'b0;
    m_gcnt   = 0;
  endtask

  task automatic model_edge(input logic din, input logic en, input logic clr);
    logic s;
    logic abort;
    s = m_q.pop_front();
    m_q.push_back(din);
    abort = 1'b0;
    if (!en) begin
      m_run = 0;
    end else if (s != m_dout) begin
      m_run++;
      if (m_run == STABLE_CNT) begin
        m_dout = s;
        m_run  = 0;
      end
    end else begin
      abort = (m_run > 0);
      m_run = 0;
    end
    m_glitch = abort;
    if (clr) m_gcnt = 0;
    if (abort) m_gcnt = (m_gcnt < GMAX) ? m_gcnt + 1 : GMAX;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clear_seen();

    // After release with din held high: sync fills on edges 1-2, QUAL on edges 3-9, dout on 10.
    for (int i = 0; i < 12; i++) begin
      tbl[i].din        = 1'b1;
      tbl[i].en         = 1'b1;
      tbl[i].clr        = 1'b0;
      tbl[i].exp_glitch = 1'b0;
      tbl[i].exp_gcnt   = 8'd0;
    end
    tbl[0].exp_busy  = 1'b0; tbl[0].exp_dout  = 1'b0;
    tbl[1].exp_busy  = 1'b0; tbl[1].exp_dout  = 1'b0;
    tbl[2].exp_busy  = 1'b1; tbl[2].exp_dout  = 1'b0;
    tbl[3].exp_busy  = 1'b1; tbl[3].exp_dout  = 1'b0;
    tbl[4].exp_busy  = 1'b1; tbl[4].exp_dout  = 1'b0;
    tbl[5].exp_busy  = 1'b1; tbl[5].exp_dout  = 1'b0;
    tbl[6].exp_busy  = 1'b1; tbl[6].exp_dout  = 1'b0;
    tbl[7].exp_busy  = 1'b1; tbl[7].exp_dout  = 1'b0;
    tbl[8].exp_busy  = 1'b1; tbl[8].exp_dout  = 1'b0;
    tbl[9].exp_busy  = 1'b0; tbl[9].exp_dout  = 1'b1;
    tbl[10].exp_busy = 1'b0; tbl[10].exp_dout = 1'b1;
    tbl[11].exp_busy = 1'b0; tbl[11].exp_dout = 1'b1;

    // Reset state with din high and the clock running.
    bus.din_async  = 1'b1;
    bus.en         = 1'b1;
    bus.clr_glitch = 1'b0;
    rst_n          = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_dout", int'(bus.dout), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_glitch", int'(bus.glitch), 0);
    check("reset_gcnt", int'(bus.glitch_cnt), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      bus.din_async  = tbl[i].din;
      bus.en         = tbl[i].en;
      bus.clr_glitch = tbl[i].clr;
      step();
      check($sformatf("tbl%0d_dout", i + 1), int'(bus.dout), int'(tbl[i].exp_dout));
      check($sformatf("tbl%0d_busy", i + 1), int'(bus.busy), int'(tbl[i].exp_busy));
      check($sformatf("tbl%0d_glitch", i + 1), int'(bus.glitch), int'(tbl[i].exp_glitch));
      check($sformatf("tbl%0d_gcnt", i + 1), int'(bus.glitch_cnt), int'(tbl[i].exp_gcnt));
    end

    // Clean rise then fall 50 cycles later.
    do_reset(1'b0);
    repeat (3) step();
    bus.din_async = 1'b1;
    repeat (9) step();
    check("clean_rise_early", int'(bus.dout), 0);
    step();
    check("clean_rise", int'(bus.dout), 1);
    repeat (40) step();
    bus.din_async = 1'b0;
    repeat (9) step();
    check("clean_fall_early", int'(bus.dout), 1);
    step();
    check("clean_fall", int'(bus.dout), 0);
    check("clean_no_glitch", glitch_seen, 0);
    check("clean_gcnt", int'(bus.glitch_cnt), 0);

    // Pulse-width rejection boundary.
    do_reset(1'b0);
    repeat (3) step();
    pulse(3);
    repeat (15) step();
    check("p3_dout", dout_hi_seen, 0);
    check("p3_glitch", glitch_seen, 1);
    check("p3_gcnt", int'(bus.glitch_cnt), 1);
    pulse(7);
    repeat (15) step();
    check("p7_dout", dout_hi_seen, 0);
    check("p7_glitch", glitch_seen, 2);
    check("p7_gcnt", int'(bus.glitch_cnt), 2);
    pulse(8);
    repeat (15) step();
    check("p8_accepted", int'(dout_hi_seen > 0), 1);
    check("p8_glitch", glitch_seen, 2);
    check("p8_gcnt", int'(bus.glitch_cnt), 2);
    check("p8_dout_back", int'(bus.dout), 0);

    // Saturation, clear coincident with an abort, then clear alone.
    do_reset(1'b0);
    repeat (3) step();
    for (int i = 0; i < 300; i++) begin
      pulse(3);
      repeat (5) step();
    end
    check("sat_gcnt", int'(bus.glitch_cnt), GMAX);
    check("sat_pulses", glitch_seen, 300);
    pulse(3);
    repeat (SYNC_STAGES) step();
    bus.clr_glitch = 1'b1;
    step();
    bus.clr_glitch = 1'b0;
    check("clr_abort_glitch", int'(bus.glitch), 1);
    check("clr_abort_gcnt", int'(bus.glitch_cnt), 1);
    repeat (3) step();
    bus.clr_glitch = 1'b1;
    step();
    bus.clr_glitch = 1'b0;
    check("clr_alone_gcnt", int'(bus.glitch_cnt), 0);

    // Enable held low freezes dout; raising it qualifies in STABLE_CNT edges.
    do_reset(1'b0);
    bus.en = 1'b0;
    bus.din_async = 1'b1;
    repeat (15) step();
    check("en_off_dout", dout_hi_seen, 0);
    check("en_off_busy", busy_seen, 0);
    bus.en = 1'b1;
    step();
    check("en_rise_busy", int'(bus.busy), 1);
    repeat (STABLE_CNT - 2) step();
    check("en_rise_early", int'(bus.dout), 0);
    step();
    check("en_rise_dout", int'(bus.dout), 1);
    clear_seen();
    bus.din_async = 1'b0;
    repeat (5) step();
    check("en_drop_busy_before", int'(bus.busy), 1);
    bus.en = 1'b0;
    step();
    check("en_drop_busy_after", int'(bus.busy), 0);
    repeat (5) step();
    check("en_drop_glitch", glitch_seen, 0);
    check("en_drop_dout", int'(bus.dout), 1);
    check("en_drop_gcnt", int'(bus.glitch_cnt), 0);
    bus.en = 1'b1;

    // Asynchronous reset in the middle of a qualification.
    do_reset(1'b0);
    pulse(3);
    repeat (6) step();
    check("rmid_gcnt_pre", int'(bus.glitch_cnt), 1);
    bus.din_async = 1'b1;
    repeat (SYNC_STAGES + 5) step();
    check("rmid_busy_pre", int'(bus.busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rmid_dout", int'(bus.dout), 0);
    check("rmid_busy", int'(bus.busy), 0);
    check("rmid_glitch", int'(bus.glitch), 0);
    check("rmid_gcnt", int'(bus.glitch_cnt), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (SYNC_STAGES + STABLE_CNT - 1) step();
    check("rmid_relat_early", int'(bus.dout), 0);
    step();
    check("rmid_relat", int'(bus.dout), 1);

    // Randomized run against the reference model.
    do_reset(1'b0);
    model_reset();
    begin
      int   hold;
      logic din_v;
      logic en_v;
      logic clr_v;
      hold  = 0;
      din_v = 1'b0;
      for (int c = 0; c < 3000; c++) begin
        if (hold == 0) begin
          din_v = ($urandom_range(0, 1) == 1);
          hold  = $urandom_range(1, 12);
        end
        hold--;
        en_v  = ($urandom_range(0, 19) != 0);
        clr_v = ($urandom_range(0, 49) == 0);
        bus.din_async  = din_v;
        bus.en         = en_v;
        bus.clr_glitch = clr_v;
        model_edge(din_v, en_v, clr_v);
        step();
        check($sformatf("rand%0d", c),
              int'({bus.dout, bus.busy, bus.glitch, bus.glitch_cnt}),
              int'({m_dout, (m_run > 0), m_glitch, GLITCH_W'(m_gcnt)}));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
